// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler: phase codes,
// default timing values and the lamp decode used for the lamp registers.
package traffic_pkg;

    // Phase codes as they appear on the phase output. Code 7 is illegal.
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PREEMPT   = 3'd6
    } phase_t;

    localparam int DEF_TICK_DIV  = 50_000_000;
    localparam int DEF_GREEN_T   = 20;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_ALLRED_T  = 1;
    localparam int DEF_MIN_GREEN = 5;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
    } lamps_t;

    // One lamp per direction; anything that is not a green or yellow of a
    // direction (all-reds, preemption, illegal code) shows red on both.
    function automatic lamps_t decode_lamps(input phase_t ph);
        lamps_t l;
        l = '0;
        case (ph)
            NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red    = 1'b1; end
            NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red    = 1'b1; end
            EW_GREEN:  begin l.ns_red    = 1'b1; l.ew_green  = 1'b1; end
            EW_YELLOW: begin l.ns_red    = 1'b1; l.ew_yellow = 1'b1; end
            default:   begin l.ns_red    = 1'b1; l.ew_red    = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle timing tick every TICK_DIV cycles.
// restart zeroes the count so a new phase always starts a whole tick period.
module tick_prescaler import traffic_pkg::*; #(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] cnt_r;

    assign tick = (cnt_r == PW'(TICK_DIV - 1));

    // Prescale counter: 0 .. TICK_DIV-1, cleared on restart or after a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (restart || tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + PW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-way intersection phase scheduler with pedestrian request latch and
// emergency preemption. phase and the lamps are registered together so they
// always change on the same edge.
module traffic_phase_scheduler import traffic_pkg::*; #(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int GREEN_T   = DEF_GREEN_T,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int MIN_GREEN = DEF_MIN_GREEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       emerg,
    output logic       ped_ack,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green
);

    localparam int MAX_A = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int MAX_B = (ALLRED_T > MIN_GREEN) ? ALLRED_T : MIN_GREEN;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAXC + 1);

    phase_t        state_r, state_next_s;
    logic [TW-1:0] tick_cnt_r, dur_m1_s;
    logic          tick_s, last_tick_s, restart_s;
    logic          pending_r, pending_next_s, pend_eff_s;
    logic          preempt_r, preempt_next_s, pre_eff_s;
    logic          walk_r, walk_next_s, ped_ack_r, ew_entry_s;
    lamps_t        lamps_r;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Duration of the current phase (in ticks, minus one) and its final tick.
    always_comb begin
        dur_m1_s = TW'(ALLRED_T - 1);
        case (state_r)
            NS_GREEN, EW_GREEN:   dur_m1_s = TW'(GREEN_T - 1);
            NS_YELLOW, EW_YELLOW: dur_m1_s = TW'(YELLOW_T - 1);
            ALLRED_A, ALLRED_B:   dur_m1_s = TW'(ALLRED_T - 1);
            default:              dur_m1_s = TW'(ALLRED_T - 1);
        endcase
        last_tick_s = tick_s && (tick_cnt_r == dur_m1_s);
    end

    // Next-state logic; a latched emergency diverts the end of an all-red.
    always_comb begin
        state_next_s = state_r;
        pre_eff_s    = preempt_r | emerg;
        case (state_r)
            NS_GREEN: begin
                if (emerg || last_tick_s ||
                    (tick_s && pending_r && (tick_cnt_r >= TW'(MIN_GREEN)))) begin
                    state_next_s = NS_YELLOW;
                end else begin
                    state_next_s = NS_GREEN;
                end
            end
            NS_YELLOW: state_next_s = last_tick_s ? ALLRED_A : NS_YELLOW;
            ALLRED_A: begin
                if (last_tick_s) begin
                    state_next_s = pre_eff_s ? PREEMPT : EW_GREEN;
                end else begin
                    state_next_s = ALLRED_A;
                end
            end
            EW_GREEN:  state_next_s = (emerg || last_tick_s) ? EW_YELLOW : EW_GREEN;
            EW_YELLOW: state_next_s = last_tick_s ? ALLRED_B : EW_YELLOW;
            ALLRED_B: begin
                if (last_tick_s) begin
                    state_next_s = pre_eff_s ? PREEMPT : NS_GREEN;
                end else begin
                    state_next_s = ALLRED_B;
                end
            end
            PREEMPT:   state_next_s = emerg ? PREEMPT : NS_GREEN;
            default:   state_next_s = ALLRED_B;
        endcase
    end

    // Timer restart, emergency latch, pedestrian latch and walk next values.
    always_comb begin
        restart_s  = (state_next_s != state_r) || (state_r == PREEMPT);
        pend_eff_s = pending_r | ped_req;
        ew_entry_s = (state_next_s == EW_GREEN) && (state_r != EW_GREEN);

        if (state_next_s == PREEMPT) begin
            preempt_next_s = 1'b0;
        end else if ((state_r != PREEMPT) && emerg) begin
            preempt_next_s = 1'b1;
        end else begin
            preempt_next_s = preempt_r;
        end

        if (ew_entry_s) begin
            pending_next_s = 1'b0;
            walk_next_s    = pend_eff_s;
        end else if (state_next_s == EW_GREEN) begin
            pending_next_s = pend_eff_s;
            walk_next_s    = walk_r;
        end else begin
            pending_next_s = pend_eff_s;
            walk_next_s    = 1'b0;
        end
    end

    // State, tick counter, latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= NS_GREEN;
            tick_cnt_r <= '0;
            pending_r  <= 1'b0;
            preempt_r  <= 1'b0;
            walk_r     <= 1'b0;
            ped_ack_r  <= 1'b0;
            lamps_r    <= decode_lamps(NS_GREEN);
        end else begin
            state_r    <= state_next_s;
            if (restart_s) begin
                tick_cnt_r <= '0;
            end else if (tick_s) begin
                tick_cnt_r <= tick_cnt_r + TW'(1);
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end
            pending_r  <= pending_next_s;
            preempt_r  <= preempt_next_s;
            walk_r     <= walk_next_s;
            ped_ack_r  <= ped_req & ~pending_r;
            lamps_r    <= decode_lamps(state_next_s);
        end
    end

    assign phase     = state_r;
    assign walk      = walk_r;
    assign ped_ack   = ped_ack_r;
    assign ns_red    = lamps_r.ns_red;
    assign ns_yellow = lamps_r.ns_yellow;
    assign ns_green  = lamps_r.ns_green;
    assign ew_red    = lamps_r.ew_red;
    assign ew_yellow = lamps_r.ew_yellow;
    assign ew_green  = lamps_r.ew_green;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed table of scenarios, an async
// reset sequence, and a randomized run against a cycle-count reference model.
module tb_traffic_phase_scheduler;

    localparam int TD = 4;
    localparam int GT = 5;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam int MG = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ped_req = 1'b0;
    logic emerg = 1'b0;
    logic ped_ack, walk;
    logic [2:0] phase;
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;

    int tests = 0;
    int fails = 0;

    traffic_phase_scheduler #(
        .TICK_DIV(TD), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .MIN_GREEN(MG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .emerg(emerg),
        .ped_ack(ped_ack), .walk(walk), .phase(phase),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green)
    );

    always #5 clk = ~clk;

    // Reference model: phase number, cycles spent in phase, latches.
    int   m_ph, m_el;
    logic m_pend, m_pre, m_walk, m_ack;

    typedef struct {
        int         n;
        logic       p;
        logic       e;
        logic [2:0] ph;
        logic       w;
        logic       a;
    } vec_t;
    vec_t vecs[$];

    function automatic int dur_ticks(input int ph);
        case (ph)
            0, 3:    return GT;
            1, 4:    return YT;
            2, 5:    return AT;
            default: return 0;
        endcase
    endfunction

    // Lamps {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g} expected for a phase code.
    function automatic logic [5:0] lamps_of(input int ph);
        logic [2:0] ns, ew;
        ns = (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
        ew = (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
        return {ns, ew};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {phase, walk, ped_ack, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (phase,walk,ack,lamps)", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_el = 0; m_pend = 1'b0; m_pre = 1'b0; m_walk = 1'b0; m_ack = 1'b0;
    endtask

    task automatic model_update(input logic p, input logic e);
        int   nxt;
        logic done, bnd, pe;
        done  = (m_el + 1 == dur_ticks(m_ph) * TD);
        bnd   = ((m_el + 1) % TD == 0);
        pe    = m_pend | p;
        m_ack = p & ~m_pend;
        nxt   = m_ph;
        case (m_ph)
            0: if (e || done || (bnd && m_pend && (m_el / TD) >= MG)) nxt = 1;
            1: if (done) nxt = 2;
            2: if (done) nxt = (m_pre || e) ? 6 : 3;
            3: if (e || done) nxt = 4;
            4: if (done) nxt = 5;
            5: if (done) nxt = (m_pre || e) ? 6 : 0;
            6: if (!e) nxt = 0;
            default: nxt = 5;
        endcase
        if (nxt == 6) m_pre = 1'b0;
        else if (m_ph != 6 && e) m_pre = 1'b1;
        if (nxt != m_ph) begin
            m_el = 0;
            if (nxt == 3) begin m_walk = pe; m_pend = 1'b0; end
            else begin m_walk = 1'b0; m_pend = pe; end
        end else begin
            m_el++;
            m_pend = pe;
        end
        m_ph = nxt;
    endtask

    // One clock: drive at negedge, model on posedge, compare at next negedge.
    task automatic step(input logic p, input logic e);
        ped_req = p;
        emerg   = e;
        @(posedge clk);
        model_update(p, e);
        @(negedge clk);
        check("model", dut_vec(), {m_ph[2:0], m_walk, m_ack, lamps_of(m_ph)});
    endtask

    task automatic add(input int n, input logic p, input logic e,
                       input int ph, input logic w, input logic a);
        vecs.push_back('{n, p, e, ph[2:0], w, a});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic em_lvl;
        // Normal cycle: dwell 20,8,4,20,8,4
        add(19,0,0,0,0,0); add(1,0,0,1,0,0); add(8,0,0,2,0,0); add(4,0,0,3,0,0);
        add(19,0,0,3,0,0); add(1,0,0,4,0,0); add(8,0,0,5,0,0); add(3,0,0,5,0,0);
        add(1,0,0,0,0,0);
        // Ped at NS_GREEN cycle 10: ack at 11, green ends after 12, walk in EW_GREEN
        add(10,0,0,0,0,0); add(1,1,0,0,0,1); add(1,0,0,1,0,0); add(8,0,0,2,0,0);
        add(4,0,0,3,1,0); add(19,0,0,3,1,0); add(1,0,0,4,0,0);
        // Ped during EW_GREEN waits for the next EW_GREEN
        add(8,0,0,5,0,0); add(4,0,0,0,0,0); add(20,0,0,1,0,0); add(8,0,0,2,0,0);
        add(4,0,0,3,0,0); add(5,0,0,3,0,0); add(1,1,0,3,0,1); add(14,0,0,4,0,0);
        add(8,0,0,5,0,0); add(4,0,0,0,0,0); add(12,0,0,1,0,0); add(8,0,0,2,0,0);
        add(4,0,0,3,1,0); add(20,0,0,4,0,0);
        // Emergency at EW_GREEN cycle 6 held 30 cycles
        add(8,0,0,5,0,0); add(4,0,0,0,0,0); add(20,0,0,1,0,0); add(8,0,0,2,0,0);
        add(4,0,0,3,0,0); add(6,0,0,3,0,0); add(1,0,1,4,0,0); add(7,0,1,4,0,0);
        add(1,0,1,5,0,0); add(3,0,1,5,0,0); add(1,0,1,6,0,0); add(17,0,1,6,0,0);
        add(1,0,0,0,0,0);
        // Emergency plus ped together in NS_YELLOW
        add(20,0,0,1,0,0); add(2,0,0,1,0,0); add(1,1,1,1,0,1); add(3,0,1,1,0,0);
        add(1,0,1,1,0,0); add(1,0,1,2,0,0); add(3,0,1,2,0,0); add(1,0,1,6,0,0);
        add(5,0,1,6,0,0); add(1,0,0,0,0,0); add(12,0,0,1,0,0); add(8,0,0,2,0,0);
        add(4,0,0,3,1,0); add(20,0,0,4,0,0);
        // Into EW_YELLOW with a pending ped request before the async reset
        add(2,0,0,4,0,0); add(1,1,0,4,0,1);

        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_state", dut_vec(), 11'b000_0_0_001100);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].p, vecs[i].e);
            check($sformatf("vec%0d", i), dut_vec(),
                  {vecs[i].ph, vecs[i].w, vecs[i].a, lamps_of(int'(vecs[i].ph))});
        end

        // Async reset mid EW_YELLOW, between edges
        ped_req = 1'b0;
        emerg   = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_vec(), 11'b000_0_0_001100);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 19; k++) step(1'b0, 1'b0);
        check("post_reset_green", dut_vec(), {3'd0, 1'b0, 1'b0, 6'b001100});
        step(1'b0, 1'b0);
        check("post_reset_yellow", dut_vec(), {3'd1, 1'b0, 1'b0, 6'b010100});

        // Randomized run against the model
        em_lvl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) em_lvl = ~em_lvl;
            step(($urandom_range(0, 15) == 0), em_lvl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
